// File: rtl/mnist_img_loader_if.sv
// Byte-stream input, image-memory write port and inference-core start/done handshake
// shared between the MNIST image loader (master) and its environment (slave).
interface mnist_img_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       pix_we;
  logic [9:0] pix_addr;
  logic [7:0] pix_data;
  logic       acc_start;
  logic       acc_done;

  modport master (
    input  s_valid, s_data, acc_done,
    output s_ready, pix_we, pix_addr, pix_data, acc_start
  );

  modport slave (
    output s_valid, s_data, acc_done,
    input  s_ready, pix_we, pix_addr, pix_data, acc_start
  );
endinterface

// File: rtl/mnist_img_loader.sv
// Loads one framed MNIST image (sync byte + pixels) into image memory, then starts the core.
// Optional trailing checksum byte enabled by defining IMG_LOADER_CHKSUM_EN.
module mnist_img_loader #(
  parameter int unsigned IMG_SIZE       = 784,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned PIX_SHIFT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  mnist_img_loader_if.master bus,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frames_done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef IMG_LOADER_CHKSUM_EN
    StCksum,
`endif
    StStart,
    StWait
  } state_e;

  state_e           r_state;
  logic [9:0]       r_count;
  logic [31:0]      r_idle;
  logic             r_pix_we;
  logic [9:0]       r_pix_addr;
  logic [7:0]       r_pix_data;
  logic             r_acc_start;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frames_done;
`ifdef IMG_LOADER_CHKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic       w_ready;
  logic       w_xfer;
  logic       w_timeout;
  logic       w_last_pix;
  logic [7:0] w_conv;

  always_comb begin
    w_ready = (r_state == StIdle) || (r_state == StLoad);
`ifdef IMG_LOADER_CHKSUM_EN
    if (r_state == StCksum) w_ready = 1'b1;
`endif
  end

  assign w_xfer     = bus.s_valid && w_ready;
  assign w_last_pix = (r_count == 10'(IMG_SIZE - 1));
  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_idle == 32'(TIMEOUT_CYCLES - 1));

  generate
    if (PIX_SHIFT > 0) begin : g_shift
      assign w_conv = {1'b0, 7'(bus.s_data >> PIX_SHIFT)};
    end else begin : g_sat
      assign w_conv = bus.s_data[7] ? 8'd127 : bus.s_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_idle        <= '0;
      r_pix_we      <= 1'b0;
      r_pix_addr    <= '0;
      r_pix_data    <= '0;
      r_acc_start   <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frames_done <= '0;
`ifdef IMG_LOADER_CHKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_pix_we   <= 1'b0;
      r_frame_ok <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_xfer && bus.s_data == SYNC_BYTE) begin
            r_state     <= StLoad;
            r_count     <= '0;
            r_idle      <= '0;
            r_frame_err <= 1'b0;
`ifdef IMG_LOADER_CHKSUM_EN
            r_sum       <= '0;
`endif
          end
        end
        StLoad: begin
          if (w_xfer) begin
            r_pix_we   <= 1'b1;
            r_pix_addr <= r_count;
            r_pix_data <= w_conv;
            r_count    <= r_count + 10'd1;
            r_idle     <= '0;
`ifdef IMG_LOADER_CHKSUM_EN
            r_sum      <= r_sum + bus.s_data;
            if (w_last_pix) r_state <= StCksum;
`else
            if (w_last_pix) r_state <= StStart;
`endif
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= StIdle;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
`ifdef IMG_LOADER_CHKSUM_EN
        StCksum: begin
          if (w_xfer) begin
            r_idle <= '0;
            if (bus.s_data == r_sum) begin
              r_state <= StStart;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StIdle;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= StIdle;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
`endif
        // Dead cycle so the final pixel write lands before the core starts reading.
        StStart: begin
          r_state     <= StWait;
          r_acc_start <= 1'b1;
        end
        StWait: begin
          if (bus.acc_done) begin
            r_acc_start   <= 1'b0;
            r_frame_ok    <= 1'b1;
            r_frames_done <= r_frames_done + 1'b1;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.s_ready   = w_ready;
  assign bus.pix_we    = r_pix_we;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.pix_data  = r_pix_data;
  assign bus.acc_start = r_acc_start;
  assign busy          = (r_state != StIdle);
  assign frame_ok      = r_frame_ok;
  assign frame_err     = r_frame_err;
  assign frames_done   = r_frames_done;

endmodule

// File: tb/tb_mnist_img_loader.sv
// Directed bench for mnist_img_loader: full frames, junk bytes, timeout, stalls, mid-frame reset.
module tb_mnist_img_loader;

  localparam int unsigned TMO = 100;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] frames_done;

  mnist_img_loader_if ifc ();

  mnist_img_loader #(
    .IMG_SIZE      (784),
    .SYNC_BYTE     (8'hA5),
    .PIX_SHIFT     (1),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc.master),
    .busy       (busy),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .frames_done(frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write monitor: every write must be the next address with data (addr%256)>>1.
  logic       mon_clr;
  int         wr_cnt;
  int         bad;
  logic       start_seen;
  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt     <= 0;
      bad        <= 0;
      start_seen <= 1'b0;
    end else begin
      if (ifc.pix_we) begin
        mem[ifc.pix_addr] <= ifc.pix_data;
        wr_cnt            <= wr_cnt + 1;
        if (ifc.pix_addr != 10'(wr_cnt) || ifc.pix_data != 8'((wr_cnt % 256) >> 1))
          bad <= bad + 1;
      end
      if (ifc.acc_start) start_seen <= 1'b1;
    end
  end

  typedef struct {
    int         addr;
    logic [7:0] data;
  } spot_t;

  spot_t spots[9];
  int    gaps[8];
  logic [7:0] junk[3];

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with s_valid low.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = b;
    while (!ifc.s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_total++;
      $display("FAIL send_ready_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    ifc.s_valid = 1'b0;
  endtask

  task automatic send_pixels(input int count, input bit use_gaps);
    for (int i = 0; i < count; i++) begin
      send(8'(i % 256));
      if (use_gaps && i < count - 1) repeat (gaps[i % 8]) @(negedge clk);
    end
  endtask

  // Entered at the negedge right after the final pixel transfer edge.
  task automatic finish_frame(input int exp_frames, input bit stall);
    check("last_we", 32'(ifc.pix_we), 1);
    check("last_addr", 32'(ifc.pix_addr), 783);
    check("start_not_early", 32'(ifc.acc_start), 0);
    check("ready_in_start", 32'(ifc.s_ready), 0);
    if (stall) begin
      ifc.s_valid = 1'b1;
      ifc.s_data  = 8'hA5;
    end
    @(negedge clk);
    check("start_rise", 32'(ifc.acc_start), 1);
    check("we_after_last", 32'(ifc.pix_we), 0);
    repeat (49) @(negedge clk);
    check("start_held", 32'(ifc.acc_start), 1);
    check("ready_in_wait", 32'(ifc.s_ready), 0);
    check("busy_in_wait", 32'(busy), 1);
    ifc.acc_done = 1'b1;
    @(negedge clk);
    ifc.acc_done = 1'b0;
    ifc.s_valid  = 1'b0;
    check("start_fall", 32'(ifc.acc_start), 0);
    check("frame_ok", 32'(frame_ok), 1);
    check("frames_done", 32'(frames_done), 32'(exp_frames));
    check("busy_idle", 32'(busy), 0);
    @(negedge clk);
    check("frame_ok_pulse", 32'(frame_ok), 0);
    check("no_extra_we", 32'(wr_cnt), 784);
    check("write_errors", 32'(bad), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    spots[0] = '{0,   8'h00};
    spots[1] = '{1,   8'h00};
    spots[2] = '{2,   8'h01};
    spots[3] = '{127, 8'h3F};
    spots[4] = '{165, 8'h52};
    spots[5] = '{255, 8'h7F};
    spots[6] = '{256, 8'h00};
    spots[7] = '{511, 8'h7F};
    spots[8] = '{783, 8'h07};
    gaps     = '{0, 3, 1, 0, 7, 2, 0, 1};
    junk     = '{8'h00, 8'hFF, 8'h12};

    rst          = 1'b1;
    ifc.s_valid  = 1'b0;
    ifc.s_data   = 8'h00;
    ifc.acc_done = 1'b0;
    mon_clr      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pix_we", 32'(ifc.pix_we), 0);
    check("rst_pix_addr", 32'(ifc.pix_addr), 0);
    check("rst_pix_data", 32'(ifc.pix_data), 0);
    check("rst_acc_start", 32'(ifc.acc_start), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_frames_done", 32'(frames_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(ifc.s_ready), 1);
    rst = 1'b0;
    clear_mon();

    // Back-to-back frame.
    send(8'hA5);
    check("busy_after_sync", 32'(busy), 1);
    send_pixels(784, 1'b0);
    finish_frame(1, 1'b0);
    foreach (spots[k]) check($sformatf("spot_%0d", spots[k].addr),
                             32'(mem[spots[k].addr]), 32'(spots[k].data));

    // Junk before sync is discarded.
    clear_mon();
    foreach (junk[k]) begin
      send(junk[k]);
      check($sformatf("junk_%0h_busy", junk[k]), 32'(busy), 0);
    end
    check("junk_no_we", 32'(wr_cnt), 0);
    send(8'hA5);
    send_pixels(784, 1'b0);
    finish_frame(2, 1'b0);

    // Timeout after 100 pixels: exact boundary at TMO idle cycles.
    clear_mon();
    send(8'hA5);
    send_pixels(100, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_before_err", 32'(frame_err), 0);
    check("tmo_before_busy", 32'(busy), 1);
    @(negedge clk);
    check("tmo_err", 32'(frame_err), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_no_start", 32'(start_seen), 0);
    check("tmo_writes", 32'(wr_cnt), 100);
    check("tmo_write_errors", 32'(bad), 0);
    send(8'hA5);
    check("sync_clears_err", 32'(frame_err), 0);
    check("sync_busy", 32'(busy), 1);
    repeat (TMO + 2) @(negedge clk);
    check("tmo_err_again", 32'(frame_err), 1);

    // Gapped frame, with a sync byte held valid during START/WAIT_DONE.
    clear_mon();
    send(8'hA5);
    check("gap_sync_clears_err", 32'(frame_err), 0);
    send_pixels(784, 1'b1);
    finish_frame(3, 1'b1);
    check("gap_idle_busy", 32'(busy), 0);
    foreach (spots[k]) check($sformatf("gap_spot_%0d", spots[k].addr),
                             32'(mem[spots[k].addr]), 32'(spots[k].data));

    // Reset after pixel 400 aborts the frame.
    clear_mon();
    send(8'hA5);
    send_pixels(401, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we", 32'(ifc.pix_we), 0);
    check("mid_rst_addr", 32'(ifc.pix_addr), 0);
    check("mid_rst_data", 32'(ifc.pix_data), 0);
    check("mid_rst_start", 32'(ifc.acc_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_frames", 32'(frames_done), 0);
    rst = 1'b0;
    clear_mon();
    send(8'hA5);
    send_pixels(784, 1'b0);
    finish_frame(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
